// File: rtl/cpu_register_bank.sv
// -----------------------------------------------------------------------------
// cpu_register_bank
//
// Purpose:
//   Parametrised CPU register set for the datapath between the control
//   sequencer and the ALU/bus mux. It contains:
//     - a NUM_REGS x WIDTH general register array with two asynchronous read
//       ports and one synchronous write port (register 0 reads as zero),
//     - a per-register busy scoreboard that tracks pending multi-cycle writes,
//     - the instruction address register (IAR) with load and increment,
//     - the accumulator (ACC) and the 4-bit FLAGS register {C, Gr, E, Z}.
//
// Parameters:
//   WIDTH     data/address width in bits
//   NUM_REGS  number of general registers (register 0 is hardwired to zero)
//   AW        register select width, NUM_REGS <= 2**AW
//   IAR_RST   IAR value after reset
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_en/wr_sel/wr_data  register write port (takes effect at the clock edge)
//   rd_a_sel/rd_a_data    read port A select and combinational data
//   rd_a_busy             busy bit of the register selected on port A
//   rd_b_sel/rd_b_data    read port B select and combinational data
//   rd_b_busy             busy bit of the register selected on port B
//   rsv_en/rsv_sel        reserve a register (mark a write as pending)
//   rsv_err               one-cycle pulse: reservation of an already-busy reg
//   iar_load/iar_inc      IAR load (wins) and increment controls
//   iar_din/iar_q         IAR load value and current value
//   acc_we/acc_din/acc_q  accumulator enable, input and value
//   flags_we/flags_in     FLAGS enable and input {C, Gr, E, Z}
//   flags_q, cin          registered flags and carry-in (flags_q[3])
//
// Configuration:
//   REG_BYPASS_EN  when defined, a read port whose select matches an active
//                  write to a writable register returns wr_data in the same
//                  cycle and reports busy 0. When undefined, read ports show
//                  the stored (old) value until the write lands.
// -----------------------------------------------------------------------------
module cpu_register_bank #(
  parameter int          WIDTH    = 8,
  parameter int          NUM_REGS = 4,
  parameter int          AW       = 2,
  parameter int unsigned IAR_RST  = 0
) (
  input  logic             clk,
  input  logic             reset,
  // register write port
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  // read port A
  input  logic [AW-1:0]    rd_a_sel,
  output logic [WIDTH-1:0] rd_a_data,
  output logic             rd_a_busy,
  // read port B
  input  logic [AW-1:0]    rd_b_sel,
  output logic [WIDTH-1:0] rd_b_data,
  output logic             rd_b_busy,
  // scoreboard reservation
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_sel,
  output logic             rsv_err,
  // instruction address register
  input  logic             iar_load,
  input  logic             iar_inc,
  input  logic [WIDTH-1:0] iar_din,
  output logic [WIDTH-1:0] iar_q,
  // accumulator
  input  logic             acc_we,
  input  logic [WIDTH-1:0] acc_din,
  output logic [WIDTH-1:0] acc_q,
  // flags {C, Gr, E, Z}
  input  logic             flags_we,
  input  logic [3:0]       flags_in,
  output logic [3:0]       flags_q,
  output logic             cin
);

  // The array is sized to the full select space so any select value indexes
  // a real entry; entries 0 and >= NUM_REGS are never written and are masked
  // on the read side.
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  // A select addresses a writable register only if it is nonzero and below
  // NUM_REGS. Writes, reservations and reads all share this qualification.
  function automatic logic writable(input logic [AW-1:0] sel);
    return (sel != '0) && (int'(sel) < NUM_REGS);
  endfunction

  // ---------------------------------------------------------------------------
  // Register array and busy scoreboard
  // ---------------------------------------------------------------------------
  // NOTE: the array is cleared on reset because software relies on all
  // registers reading zero after reset; this forces flops rather than RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy    <= '0;
      rsv_err <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en && (wr_sel == AW'(i))) begin
          regs[i] <= wr_data;
        end
        // A reservation in the same cycle as the completing write belongs to
        // the next producer, so it takes priority over the clear.
        if (rsv_en && (rsv_sel == AW'(i))) begin
          busy[i] <= 1'b1;
        end else if (wr_en && (wr_sel == AW'(i))) begin
          busy[i] <= 1'b0;
        end
      end
      // NOTE: non-blocking assignment samples busy before this edge's update,
      // so the error reflects the register's state when the reserve was seen.
      rsv_err <= rsv_en && writable(rsv_sel) && busy[rsv_sel];
    end
  end

  // ---------------------------------------------------------------------------
  // Asynchronous read ports
  // ---------------------------------------------------------------------------
  // NOTE: every output is given a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_a_data = '0;
    rd_a_busy = 1'b0;
    if (writable(rd_a_sel)) begin
      rd_a_data = regs[rd_a_sel];
      rd_a_busy = busy[rd_a_sel];
`ifdef REG_BYPASS_EN
      // rd_a_sel is writable here, so a match implies wr_sel is writable too.
      if (wr_en && (wr_sel == rd_a_sel)) begin
        rd_a_data = wr_data;
        rd_a_busy = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rd_b_data = '0;
    rd_b_busy = 1'b0;
    if (writable(rd_b_sel)) begin
      rd_b_data = regs[rd_b_sel];
      rd_b_busy = busy[rd_b_sel];
`ifdef REG_BYPASS_EN
      if (wr_en && (wr_sel == rd_b_sel)) begin
        rd_b_data = wr_data;
        rd_b_busy = 1'b0;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // IAR: load beats increment; the increment wraps naturally at 2**WIDTH.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      iar_q <= WIDTH'(IAR_RST);
    end else if (iar_load) begin
      iar_q <= iar_din;
    end else if (iar_inc) begin
      iar_q <= iar_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // ACC and FLAGS: plain enabled registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      if (acc_we) begin
        acc_q <= acc_din;
      end
      if (flags_we) begin
        flags_q <= flags_in;
      end
    end
  end

  // Carry flag feeds the ALU carry-in directly.
  assign cin = flags_q[3];

endmodule

// File: tb/tb_cpu_register_bank.sv
// -----------------------------------------------------------------------------
// tb_cpu_register_bank
//
// Directed bench for cpu_register_bank (WIDTH=8, NUM_REGS=4, AW=2,
// IAR_RST=8'h10). Each vector drives inputs just after a rising edge and
// queues the outputs expected during that cycle; a monitor pops one entry on
// every falling edge and compares only the fields the entry selects.
// -----------------------------------------------------------------------------
module tb_cpu_register_bank;

  localparam int W = 8;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // field select bits for an expectation entry
  localparam logic [6:0] M_A     = 7'b000_0001;
  localparam logic [6:0] M_B     = 7'b000_0010;
  localparam logic [6:0] M_ERR   = 7'b000_0100;
  localparam logic [6:0] M_IAR   = 7'b000_1000;
  localparam logic [6:0] M_ACC   = 7'b001_0000;
  localparam logic [6:0] M_FLAGS = 7'b010_0000;

  typedef struct {
    string      name;
    logic [6:0] mask;
    logic [7:0] rd_a;
    logic       a_busy;
    logic [7:0] rd_b;
    logic       b_busy;
    logic       rsv_err;
    logic [7:0] iar;
    logic [7:0] acc;
    logic [3:0] flags;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [1:0]   wr_sel;
  logic [W-1:0] wr_data;
  logic [1:0]   rd_a_sel;
  logic [W-1:0] rd_a_data;
  logic         rd_a_busy;
  logic [1:0]   rd_b_sel;
  logic [W-1:0] rd_b_data;
  logic         rd_b_busy;
  logic         rsv_en;
  logic [1:0]   rsv_sel;
  logic         rsv_err;
  logic         iar_load;
  logic         iar_inc;
  logic [W-1:0] iar_din;
  logic [W-1:0] iar_q;
  logic         acc_we;
  logic [W-1:0] acc_din;
  logic [W-1:0] acc_q;
  logic         flags_we;
  logic [3:0]   flags_in;
  logic [3:0]   flags_q;
  logic         cin;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  cpu_register_bank #(
    .WIDTH    (8),
    .NUM_REGS (4),
    .AW       (2),
    .IAR_RST  (32'h10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_a_sel  (rd_a_sel),
    .rd_a_data (rd_a_data),
    .rd_a_busy (rd_a_busy),
    .rd_b_sel  (rd_b_sel),
    .rd_b_data (rd_b_data),
    .rd_b_busy (rd_b_busy),
    .rsv_en    (rsv_en),
    .rsv_sel   (rsv_sel),
    .rsv_err   (rsv_err),
    .iar_load  (iar_load),
    .iar_inc   (iar_inc),
    .iar_din   (iar_din),
    .iar_q     (iar_q),
    .acc_we    (acc_we),
    .acc_din   (acc_din),
    .acc_q     (acc_q),
    .flags_we  (flags_we),
    .flags_in  (flags_in),
    .flags_q   (flags_q),
    .cin       (cin)
  );

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if ((e.mask & M_A) != 0) begin
        check({e.name, ".rd_a_data"}, 32'(rd_a_data), 32'(e.rd_a));
        check({e.name, ".rd_a_busy"}, 32'(rd_a_busy), 32'(e.a_busy));
      end
      if ((e.mask & M_B) != 0) begin
        check({e.name, ".rd_b_data"}, 32'(rd_b_data), 32'(e.rd_b));
        check({e.name, ".rd_b_busy"}, 32'(rd_b_busy), 32'(e.b_busy));
      end
      if ((e.mask & M_ERR) != 0)
        check({e.name, ".rsv_err"}, 32'(rsv_err), 32'(e.rsv_err));
      if ((e.mask & M_IAR) != 0)
        check({e.name, ".iar_q"}, 32'(iar_q), 32'(e.iar));
      if ((e.mask & M_ACC) != 0)
        check({e.name, ".acc_q"}, 32'(acc_q), 32'(e.acc));
      if ((e.mask & M_FLAGS) != 0) begin
        check({e.name, ".flags_q"}, 32'(flags_q), 32'(e.flags));
        check({e.name, ".cin"}, 32'(cin), 32'(e.flags[3]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    reset    = 1'b0;
    wr_en    = 1'b0;  wr_sel  = '0;  wr_data = '0;
    rd_a_sel = '0;    rd_b_sel = '0;
    rsv_en   = 1'b0;  rsv_sel = '0;
    iar_load = 1'b0;  iar_inc = 1'b0; iar_din = '0;
    acc_we   = 1'b0;  acc_din = '0;
    flags_we = 1'b0;  flags_in = '0;
  endtask

  task automatic begin_vec(input string name);
    idle_inputs();
    cur.name  = name;
    cur.mask  = '0;
    cur.rd_a  = '0; cur.a_busy = 1'b0;
    cur.rd_b  = '0; cur.b_busy = 1'b0;
    cur.rsv_err = 1'b0;
    cur.iar   = '0; cur.acc = '0; cur.flags = '0;
  endtask

  task automatic e_a(input logic [7:0] d, input logic b);
    cur.mask |= M_A; cur.rd_a = d; cur.a_busy = b;
  endtask
  task automatic e_b(input logic [7:0] d, input logic b);
    cur.mask |= M_B; cur.rd_b = d; cur.b_busy = b;
  endtask
  task automatic e_err(input logic v);
    cur.mask |= M_ERR; cur.rsv_err = v;
  endtask
  task automatic e_iar(input logic [7:0] v);
    cur.mask |= M_IAR; cur.iar = v;
  endtask
  task automatic e_acc(input logic [7:0] v);
    cur.mask |= M_ACC; cur.acc = v;
  endtask
  task automatic e_flags(input logic [3:0] v);
    cur.mask |= M_FLAGS; cur.flags = v;
  endtask

  task automatic end_vec();
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
  endtask
  task automatic rsv(input logic [1:0] sel);
    rsv_en = 1'b1; rsv_sel = sel;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    begin_vec("reset_state");
    rd_a_sel = 2'd2; rd_b_sel = 2'd3;
    e_a(8'h00, 1'b0); e_b(8'h00, 1'b0); e_err(1'b0);
    e_iar(8'h10); e_acc(8'h00); e_flags(4'b0000);
    end_vec();

    begin_vec("wr_r2");
    wr(2'd2, 8'hA5); rd_a_sel = 2'd2; rd_b_sel = 2'd0;
    e_a(BYP ? 8'hA5 : 8'h00, 1'b0); e_b(8'h00, 1'b0);
    end_vec();

    begin_vec("wr_r0");
    wr(2'd0, 8'hFF); rd_a_sel = 2'd2; rd_b_sel = 2'd0;
    e_a(8'hA5, 1'b0); e_b(8'h00, 1'b0);
    end_vec();

    begin_vec("r0_dropped");
    rd_a_sel = 2'd2; rd_b_sel = 2'd0;
    e_a(8'hA5, 1'b0); e_b(8'h00, 1'b0);
    end_vec();

    begin_vec("rsv_r3");
    rsv(2'd3); rd_a_sel = 2'd3;
    e_a(8'h00, 1'b0); e_err(1'b0);
    end_vec();

    begin_vec("rsv_r3_again");
    rsv(2'd3); rd_a_sel = 2'd3; rd_b_sel = 2'd3;
    e_a(8'h00, 1'b1); e_b(8'h00, 1'b1); e_err(1'b0);
    end_vec();

    begin_vec("wr_r3_err");
    wr(2'd3, 8'h3C); rd_a_sel = 2'd3;
    e_a(BYP ? 8'h3C : 8'h00, !BYP); e_err(1'b1);
    end_vec();

    begin_vec("r3_done");
    rd_a_sel = 2'd3;
    e_a(8'h3C, 1'b0); e_err(1'b0);
    end_vec();

    begin_vec("rsv_r0");
    rsv(2'd0); rd_a_sel = 2'd0;
    e_a(8'h00, 1'b0); e_err(1'b0);
    end_vec();

    begin_vec("rsv_r0_ignored");
    rd_a_sel = 2'd0;
    e_a(8'h00, 1'b0); e_err(1'b0);
    end_vec();

    begin_vec("rsv_wr_r1");
    rsv(2'd1); wr(2'd1, 8'h11);
    end_vec();

    begin_vec("bypass_r1");
    wr(2'd1, 8'h55); rd_a_sel = 2'd1;
    e_a(BYP ? 8'h55 : 8'h11, !BYP); e_err(1'b0);
    end_vec();

    begin_vec("r1_written");
    rd_a_sel = 2'd1;
    e_a(8'h55, 1'b0);
    end_vec();

    begin_vec("iar_load_ff");
    iar_load = 1'b1; iar_din = 8'hFF;
    e_iar(8'h10);
    end_vec();

    begin_vec("iar_inc");
    iar_inc = 1'b1;
    e_iar(8'hFF);
    end_vec();

    begin_vec("iar_load_inc");
    iar_load = 1'b1; iar_inc = 1'b1; iar_din = 8'h20;
    e_iar(8'h00);
    end_vec();

    begin_vec("acc_flags_load");
    acc_we = 1'b1; acc_din = 8'hAA; flags_we = 1'b1; flags_in = 4'b1010;
    e_iar(8'h20); e_acc(8'h00); e_flags(4'b0000);
    end_vec();

    begin_vec("acc_flags_q");
    acc_din = 8'h77; flags_in = 4'b0101;
    e_iar(8'h20); e_acc(8'hAA); e_flags(4'b1010);
    end_vec();

    begin_vec("acc_flags_hold");
    rsv(2'd2);
    e_acc(8'hAA); e_flags(4'b1010);
    end_vec();

    begin_vec("reset_mid_rsv");
    reset = 1'b1; rsv(2'd2); wr(2'd1, 8'h77); rd_a_sel = 2'd2;
    e_a(8'hA5, 1'b1); e_err(1'b0);
    end_vec();

    begin_vec("after_reset");
    rd_a_sel = 2'd2; rd_b_sel = 2'd1;
    e_a(8'h00, 1'b0); e_b(8'h00, 1'b0); e_err(1'b0);
    e_iar(8'h10); e_acc(8'h00); e_flags(4'b0000);
    end_vec();

    idle_inputs();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
